present_arbiter: RTL
====================

Name: present_arbiter

Overview:
- Shares one PRESENT encryption engine (datapath plus its round controller) between N_REQ requesters.
- Arbitrates round-robin and captures the winner's plaintext and key into operand registers.
- Pulses the engine start, waits for end-of-computation, and returns the ciphertext to the winner over a valid/ready response channel.
- A watchdog flags an engine that never signals eoc. Sits between the bus-side request ports and the engine instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 64, block width.
- KEY_W, 80, key width.
- WDOG_CYCLES, 64, maximum BUSY cycles before timeout.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept; one-hot or zero.
- req_data  in  N_REQ*DATA_W  plaintexts; requester i occupies bits [i*DATA_W +: DATA_W].
- req_key  in  N_REQ*KEY_W  keys; same packing as req_data.
- rsp_valid  out  N_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester response accept.
- rsp_data  out  DATA_W  ciphertext, shared by all requesters.
- rsp_err  out  1  response carries a watchdog timeout.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_plaintext  out  DATA_W  registered operand.
- eng_key  out  KEY_W  registered operand.
- eng_eoc  in  1  engine end-of-computation pulse.
- eng_ciphertext  in  DATA_W  engine result, valid when eng_eoc=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Round-robin pointer rr_ptr = 0.
  - Grant index, operand registers, result register and watchdog counter all 0.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around modulo N_REQ.
  - req_ready[grant] = 1 combinationally; all other req_ready bits 0.
  - On transfer (req_valid & req_ready):
    - latch req_data/req_key slices into eng_plaintext/eng_key;
    - store the grant index;
    - rr_ptr <= (grant+1) mod N_REQ;
    - go to LOAD.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- LOAD: eng_start = 1 for exactly this cycle; go to BUSY; clear the watchdog counter.
- BUSY:
  - req_ready all 0; watchdog counter increments each cycle.
  - eng_eoc = 1: capture eng_ciphertext into rsp_data, rsp_err = 0, go to RESP.
  - Counter reaches WDOG_CYCLES-1 with eng_eoc = 0: rsp_data = 0, rsp_err = 1, go to RESP.
  - eng_eoc and timeout in the same cycle: eoc wins (rsp_err = 0).
- RESP:
  - rsp_valid[grant] = 1; rsp_data and rsp_err held stable while rsp_valid is high.
  - rsp_ready[grant] = 1: go to IDLE next cycle.
  - rsp_ready bits of non-granted requesters are ignored.
- eng_eoc outside BUSY is ignored.
- Latency: with the engine's eoc arriving E cycles after start, request transfer to rsp_valid is E+2 cycles.
  - Example: E = 30 (N_ROUNDS=31, ROUNDS_PER_CYCLE=1) gives 32 cycles.
- Back-to-back:
  - A request waiting during RESP is granted in the IDLE cycle that follows.
  - No request is accepted in the same cycle as a response handshake.
- Fairness: a requester holding req_valid is granted within N_REQ transactions.
- Operands stay stable from LOAD until the next grant.
- Asynchronous reset mid-operation returns the FSM to IDLE with all outputs 0. The engine shares nrst, so no flush is needed.

Decomposition:
- Shared package present_pkg holds:
  - DATA_W/KEY_W defaults;
  - enum arb_state_t {IDLE, LOAD, BUSY, RESP};
  - a function rr_pick(valid, ptr) returning the grant index and a found flag.
- Optional sub-module present_rr_arbiter: combinational round-robin pick plus the registered pointer. The FSM, operand registers and watchdog stay in the top level.

Test Plan:
- Single request: requester 0, key 0x0, plaintext 0x0 -> eng_start one cycle after transfer; rsp_valid[0] rises 32 cycles after transfer; rsp_data = 0x5579C1387B228445; rsp_err = 0.
- Contention: N_REQ=2, both requesters valid continuously from reset -> grants alternate 0,1,0,1; each rsp_valid is one-hot on the matching bit.
- Response backpressure: rsp_ready[0] held low for 10 cycles -> rsp_valid[0] and rsp_data stable throughout; no new req_ready until the handshake completes and one IDLE cycle passes.
- Watchdog: engine stub never asserts eng_eoc -> exactly WDOG_CYCLES=64 BUSY cycles, then RESP with rsp_err=1, rsp_data=0.
- Coincident eoc and timeout: stub asserts eng_eoc on the 64th BUSY cycle -> rsp_err=0, ciphertext captured.
- Reset mid-BUSY: nrst low for 2 cycles -> busy, rsp_valid, req_ready, eng_start all 0 immediately; rr_ptr=0; the next request is served normally.

Source files
------------

// File: rtl/present_pkg.sv
// present_pkg: shared widths, FSM states and the
// round-robin pick helper for the PRESENT arbiter.
package present_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int KEY_W_DEF  = 80;
    localparam int MAX_REQ    = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (ptr + k) % n;
            if (k < n && !r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/present_rr_arbiter.sv
// present_rr_arbiter: combinational round-robin
// pick with the registered rotation pointer.
module present_rr_arbiter
    import present_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_REQ-1:0] valid,
    input  logic             advance,
    output logic [IW-1:0]    grant,
    output logic             found
);

    logic [IW-1:0]      ptr;
    logic [MAX_REQ-1:0] v8;
    rr_pick_t           pick;

    // first valid requester at or above the pointer, wrapping
    always_comb begin
        v8 = '0;
        v8[N_REQ-1:0] = valid;
        pick = rr_pick(v8, int'(ptr), N_REQ);
        found = pick.found;
        grant = IW'(pick.idx);
    end

    // winner's successor becomes the highest-priority requester
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            ptr <= '0;
        else if (advance)
            ptr <= IW'((int'(grant) + 1) % N_REQ);
    end

endmodule

// File: rtl/present_arbiter.sv
// present_arbiter: shares one PRESENT engine between
// N_REQ requesters with a round-robin grant and watchdog.
module present_arbiter
    import present_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int KEY_W       = KEY_W_DEF,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*KEY_W-1:0]  req_key,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   eng_start,
    output logic [DATA_W-1:0]      eng_plaintext,
    output logic [KEY_W-1:0]       eng_key,
    input  logic                   eng_eoc,
    input  logic [DATA_W-1:0]      eng_ciphertext,
    output logic                   busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(WDOG_CYCLES);

    arb_state_t    state;
    arb_state_t    nxt;
    logic [IW-1:0] grant;
    logic          found;
    logic [IW-1:0] gnt_q;
    logic [WW-1:0] wd_cnt;
    logic          xfer;
    logic          wd_to;

    present_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .clk(clk),
        .nrst(nrst),
        .valid(req_valid),
        .advance(xfer),
        .grant(grant),
        .found(found)
    );

    assign wd_to = (wd_cnt == WW'(WDOG_CYCLES - 1));
    assign busy  = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // next state and handshake outputs; ready is masked in reset
    always_comb begin
        nxt       = state;
        xfer      = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && nrst) begin
                    req_ready = N_REQ'(1) << grant;
                    xfer      = 1'b1;
                    nxt       = LOAD;
                end
            end
            LOAD: begin
                eng_start = 1'b1;
                nxt       = BUSY;
            end
            BUSY: begin
                if (eng_eoc || wd_to)
                    nxt = RESP;
            end
            RESP: begin
                rsp_valid = N_REQ'(1) << gnt_q;
                if (rsp_ready[gnt_q])
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // operands, grant, watchdog and result; eoc beats timeout
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            eng_plaintext <= '0;
            eng_key       <= '0;
            gnt_q         <= '0;
            wd_cnt        <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            if (xfer) begin
                eng_plaintext <= req_data[grant*DATA_W +: DATA_W];
                eng_key       <= req_key[grant*KEY_W +: KEY_W];
                gnt_q         <= grant;
            end
            if (state == LOAD)
                wd_cnt <= '0;
            else if (state == BUSY)
                wd_cnt <= wd_cnt + WW'(1);
            if (state == BUSY) begin
                if (eng_eoc) begin
                    rsp_data <= eng_ciphertext;
                    rsp_err  <= 1'b0;
                end else if (wd_to) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule
